// File: rtl/blk_motion.sv
// blk_motion -- per-frame player-block physics engine.
//
// Moves the player block once per video frame:
//   - button-driven horizontal motion (clamped at the arena borders),
//   - gravity while falling,
//   - landing on and riding the scrolling platforms published by the renderer,
//   - death when crushed against the top border or when reaching the floor.
//
// Build option:
//   BLK_WRAP_X_EN  when defined, horizontal motion wraps around the arena
//                  instead of clamping at the borders.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   frame_tick              one-clk pulse per frame; the only time state moves
//   start                   begin / restart play (level)
//   btn_l, btn_r            move left / right
//   top1..top5     [9:0]    platform top y
//   leftgap1..3    [10:0]   gap start x
//   rightgap1..3   [10:0]   gap end x
//   blkpos_x       [10:0]   block left x (registered)
//   blkpos_y       [9:0]    block top y (registered)
//   game_over               high while dead
//   score          [7:0]    platforms landed on, saturating at 255
module blk_motion #(
  parameter int unsigned BLK_SIZE  = 32,
  parameter int unsigned XMIN      = 10,
  parameter int unsigned XMAX      = 1429,
  parameter int unsigned YMIN      = 10,
  parameter int unsigned YMAX      = 889,
  parameter int unsigned HSTEP     = 4,
  parameter int unsigned FALL_STEP = 4,
  parameter int unsigned X_START   = 700,
  parameter int unsigned Y_START   = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic [9:0]  top1,
  input  logic [9:0]  top2,
  input  logic [9:0]  top3,
  input  logic [9:0]  top4,
  input  logic [9:0]  top5,
  input  logic [10:0] leftgap1,
  input  logic [10:0] leftgap2,
  input  logic [10:0] leftgap3,
  input  logic [10:0] rightgap1,
  input  logic [10:0] rightgap2,
  input  logic [10:0] rightgap3,
  output logic [10:0] blkpos_x,
  output logic [9:0]  blkpos_y,
  output logic        game_over,
  output logic [7:0]  score
);

  typedef enum logic [1:0] {IDLE, FALL, RIDE, DEAD} state_t;

  // All geometry is evaluated in 12 bits so sums never wrap.
  localparam logic [11:0] BLK12    = 12'(BLK_SIZE);
  localparam logic [11:0] HSTEP12  = 12'(HSTEP);
  localparam logic [11:0] FSTEP12  = 12'(FALL_STEP);
  localparam logic [11:0] X_LO     = 12'(XMIN + 1);
  localparam logic [11:0] X_HI     = 12'(XMAX - 1 - BLK_SIZE);
  localparam logic [11:0] YMIN12   = 12'(YMIN);
  localparam logic [11:0] YMAX12   = 12'(YMAX);
  localparam logic [11:0] CRUSH_TOP = 12'(YMIN + BLK_SIZE + 1);
  localparam logic [11:0] REST_OFF = 12'(BLK_SIZE + 1);
  localparam logic [10:0] X_SPAWN  = 11'(X_START);
  localparam logic [9:0]  Y_SPAWN  = 10'(Y_START);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [7:0]  score_q, score_d;
  logic        go_q, go_d;
  logic [2:0]  ride_q, ride_d;

  logic [11:0] top_w   [5];
  logic [11:0] lgap_w  [5];
  logic [11:0] rgap_w  [5];
  logic [11:0] x_mv;
  logic [4:0]  solid;
  logic [11:0] bottom;
  logic        found;
  logic [11:0] best_top;
  logic [2:0]  best_k;
  logic [11:0] ride_top;
  logic        ride_solid;
  logic [11:0] y_new;
  logic        crush;
  logic        moved;

  // Resting y above a platform top; clamps at 0 instead of underflowing.
  function automatic logic [11:0] rest_y(input logic [11:0] top);
    if (top < REST_OFF) return '0;
    return top - REST_OFF;
  endfunction

  // Platforms 1/4 share gap1, 2/5 share gap2, 3 uses gap3.
  always_comb begin
    top_w[0]  = {2'b00, top1};
    top_w[1]  = {2'b00, top2};
    top_w[2]  = {2'b00, top3};
    top_w[3]  = {2'b00, top4};
    top_w[4]  = {2'b00, top5};
    lgap_w[0] = {1'b0, leftgap1};
    lgap_w[1] = {1'b0, leftgap2};
    lgap_w[2] = {1'b0, leftgap3};
    lgap_w[3] = {1'b0, leftgap1};
    lgap_w[4] = {1'b0, leftgap2};
    rgap_w[0] = {1'b0, rightgap1};
    rgap_w[1] = {1'b0, rightgap2};
    rgap_w[2] = {1'b0, rightgap3};
    rgap_w[3] = {1'b0, rightgap1};
    rgap_w[4] = {1'b0, rightgap2};
  end

  // Candidate horizontal position for this frame.
  always_comb begin
    x_mv = {1'b0, x_q};
    if (btn_l && !btn_r) begin
      if (x_mv < X_LO + HSTEP12) begin
`ifdef BLK_WRAP_X_EN
        x_mv = X_HI;
`else
        x_mv = X_LO;
`endif
      end else begin
        x_mv = x_mv - HSTEP12;
      end
    end else if (btn_r && !btn_l) begin
      if (x_mv + HSTEP12 > X_HI) begin
`ifdef BLK_WRAP_X_EN
        x_mv = X_LO;
`else
        x_mv = X_HI;
`endif
      end else begin
        x_mv = x_mv + HSTEP12;
      end
    end
  end

  // Support and landing search, all against the new x.
  always_comb begin
    bottom     = {2'b00, y_q} + BLK12;
    solid      = '0;
    found      = 1'b0;
    best_top   = '0;
    best_k     = '0;
    ride_top   = '0;
    ride_solid = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      solid[k] = (x_mv < lgap_w[k]) || (x_mv + BLK12 > rgap_w[k]);
      // Strict < keeps the lowest index on equal tops.
      if (solid[k] && (top_w[k] > bottom) && (top_w[k] <= bottom + FSTEP12 + 12'd1) &&
          (!found || (top_w[k] < best_top))) begin
        found    = 1'b1;
        best_top = top_w[k];
        best_k   = 3'(k);
      end
      if (ride_q == 3'(k)) begin
        ride_top   = top_w[k];
        ride_solid = solid[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    score_d = score_q;
    go_d    = go_q;
    ride_d  = ride_q;
    y_new   = {2'b00, y_q};
    crush   = 1'b0;
    moved   = 1'b0;

    if (frame_tick) begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = FALL;
        end
        DEAD: begin
          if (start) begin
            x_d     = X_SPAWN;
            y_d     = Y_SPAWN;
            score_d = '0;
            go_d    = 1'b0;
            state_d = FALL;
          end
        end
        FALL: begin
          moved = 1'b1;
          if (found) begin
            y_new   = rest_y(best_top);
            ride_d  = best_k;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            state_d = RIDE;
          end else begin
            y_new = y_new + FSTEP12;
          end
        end
        RIDE: begin
          moved = 1'b1;
          crush = (ride_top <= CRUSH_TOP);
          if (!ride_solid) state_d = FALL;
          else             y_new   = rest_y(ride_top);
        end
        default: state_d = IDLE;
      endcase
    end

    // Death checks see the y produced on this same tick.
    if (moved) begin
      x_d = x_mv[10:0];
      y_d = y_new[9:0];
      if ((y_new <= YMIN12) || crush || (y_new + BLK12 >= YMAX12)) begin
        state_d = DEAD;
        go_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= X_SPAWN;
      y_q     <= Y_SPAWN;
      score_q <= '0;
      go_q    <= 1'b0;
      ride_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      score_q <= score_d;
      go_q    <= go_d;
      ride_q  <= ride_d;
    end
  end

  assign blkpos_x  = x_q;
  assign blkpos_y  = y_q;
  assign game_over = go_q;
  assign score     = score_q;

endmodule

// File: tb/tb_blk_motion.sv
// Self-checking bench for blk_motion: a behavioural model predicts every
// frame's outputs, the prediction is queued when the frame is driven and
// compared once the DUT has registered it.
module tb_blk_motion;

  logic        clk = 1'b0;
  logic        rst_n, frame_tick, start, btn_l, btn_r;
  logic [9:0]  top1, top2, top3, top4, top5;
  logic [10:0] leftgap1, leftgap2, leftgap3;
  logic [10:0] rightgap1, rightgap2, rightgap3;
  logic [10:0] blkpos_x;
  logic [9:0]  blkpos_y;
  logic        game_over;
  logic [7:0]  score;

  always #5 clk = ~clk;

  blk_motion dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .start     (start),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .top1      (top1),
    .top2      (top2),
    .top3      (top3),
    .top4      (top4),
    .top5      (top5),
    .leftgap1  (leftgap1),
    .leftgap2  (leftgap2),
    .leftgap3  (leftgap3),
    .rightgap1 (rightgap1),
    .rightgap2 (rightgap2),
    .rightgap3 (rightgap3),
    .blkpos_x  (blkpos_x),
    .blkpos_y  (blkpos_y),
    .game_over (game_over),
    .score     (score)
  );

  typedef enum {M_IDLE, M_FALL, M_RIDE, M_DEAD} m_state_t;
  typedef struct { int x; int y; int go; int sc; } exp_t;

  exp_t     sb_q[$];
  int       n_tests = 0;
  int       n_fail  = 0;

  // Model state
  int       mx, my, msc, mgo, mk;
  m_state_t mst;
  int       tops[5];
  int       gl[3];
  int       gr[3];
  int       gmap[5] = '{0, 1, 2, 0, 1};

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_plat();
    top1 = 10'(tops[0]); top2 = 10'(tops[1]); top3 = 10'(tops[2]);
    top4 = 10'(tops[3]); top5 = 10'(tops[4]);
    leftgap1  = 11'(gl[0]); leftgap2  = 11'(gl[1]); leftgap3  = 11'(gl[2]);
    rightgap1 = 11'(gr[0]); rightgap2 = 11'(gr[1]); rightgap3 = 11'(gr[2]);
  endtask

  task automatic set_all(input int t, input int l, input int r);
    for (int i = 0; i < 5; i++) tops[i] = t;
    for (int i = 0; i < 3; i++) begin gl[i] = l; gr[i] = r; end
    apply_plat();
  endtask

  function automatic bit msolid(input int x, input int k);
    return (x < gl[gmap[k]]) || (x + 32 > gr[gmap[k]]);
  endfunction

  task automatic model_reset();
    mx = 700; my = 100; msc = 0; mgo = 0; mk = 0; mst = M_IDLE;
  endtask

  task automatic model_step();
    int nx, ny, bot, bk, bt;
    bit crush;
    m_state_t nst;
    case (mst)
      M_IDLE: if (start) mst = M_FALL;
      M_DEAD: if (start) begin
        mx = 700; my = 100; msc = 0; mgo = 0; mst = M_FALL;
      end
      default: begin
        nx = mx;
        if (btn_l && !btn_r) begin
          nx = mx - 4;
`ifdef BLK_WRAP_X_EN
          if (nx < 11) nx = 1396;
`else
          if (nx < 11) nx = 11;
`endif
        end else if (btn_r && !btn_l) begin
          nx = mx + 4;
`ifdef BLK_WRAP_X_EN
          if (nx > 1396) nx = 11;
`else
          if (nx > 1396) nx = 1396;
`endif
        end
        ny = my; nst = mst; crush = 0;
        if (mst == M_FALL) begin
          bot = my + 32; bk = -1; bt = 0;
          for (int k = 0; k < 5; k++)
            if (msolid(nx, k) && tops[k] > bot && tops[k] <= bot + 5 && (bk < 0 || tops[k] < bt)) begin
              bk = k; bt = tops[k];
            end
          if (bk >= 0) begin
            ny = (bt >= 33) ? bt - 33 : 0;
            mk = bk;
            if (msc < 255) msc++;
            nst = M_RIDE;
          end else begin
            ny = my + 4;
          end
        end else begin
          crush = (tops[mk] <= 43);
          if (!msolid(nx, mk)) nst = M_FALL;
          else ny = (tops[mk] >= 33) ? tops[mk] - 33 : 0;
        end
        if (ny <= 10 || crush || ny + 32 >= 889) begin
          nst = M_DEAD; mgo = 1;
        end
        mx = nx; my = ny; mst = nst;
      end
    endcase
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", sb_q.size(), 1);
      return;
    end
    e = sb_q.pop_front();
    check("blkpos_x",  int'(blkpos_x),  e.x);
    check("blkpos_y",  int'(blkpos_y),  e.y);
    check("game_over", int'(game_over), e.go);
    check("score",     int'(score),     e.sc);
  endtask

  // One frame: drive inputs with frame_tick, predict, then compare after the edge.
  task automatic tick(input bit s, input bit l, input bit r);
    start = s; btn_l = l; btn_r = r; frame_tick = 1'b1;
    model_step();
    sb_q.push_back('{mx, my, mgo, msc});
    @(posedge clk); #1;
    frame_tick = 1'b0; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
    compare_out();
  endtask

  // Clocks without frame_tick: outputs must hold even with active inputs.
  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b1; btn_r = 1'b1; frame_tick = 1'b0;
      sb_q.push_back('{mx, my, mgo, msc});
      @(posedge clk); #1;
      compare_out();
    end
    start = 1'b0; btn_r = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"},  int'(blkpos_x),  700);
    check({tag, "_y"},  int'(blkpos_y),  100);
    check({tag, "_go"}, int'(game_over), 0);
    check({tag, "_sc"}, int'(score),     0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
    set_all(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    model_reset();

    // IDLE ignores everything without a tick, and a tick without start.
    hold_cycles(3);
    tick(0, 0, 1);

    // Spawn and fall onto platforms at 800 with gaps 200..450.
    set_all(800, 200, 450);
    tick(1, 0, 0);
    repeat (3) tick(0, 0, 0);
    check("fall_3_y", int'(blkpos_y), 112);
    check("fall_3_x", int'(blkpos_x), 700);
    for (int i = 0; i < 200 && mst == M_FALL; i++) tick(0, 0, 0);
    check("land_y", int'(blkpos_y), 767);
    check("land_score", int'(score), 1);

    // Ride a platform scrolling upward.
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 5; k++) tops[k] = tops[k] - 2;
      apply_plat();
      tick(0, 0, 0);
    end
    check("ride_track_y", int'(blkpos_y), 757);
    hold_cycles(2);

    // Walk left until fully inside the gap, then drop through it to the floor.
    for (int i = 0; i < 100 && mst == M_RIDE; i++) tick(0, 1, 0);
    check("gap_x", int'(blkpos_x), 416);
    tick(0, 0, 0);
    check("gap_fall_y", int'(blkpos_y), 761);
    for (int i = 0; i < 100 && mst != M_DEAD; i++) tick(0, 0, 0);
    check("floor_go", int'(game_over), 1);
    hold_cycles(2);
    tick(0, 1, 1);

    // Respawn onto always-solid platforms, then drive the right border.
    set_all(790, 0, 0);
    tick(1, 0, 0);
    check_reset_vals("respawn");
    for (int i = 0; i < 200 && mst == M_FALL; i++) tick(0, 0, 0);
    check("land2_y", int'(blkpos_y), 757);
    for (int i = 0; i < 200; i++) tick(0, 0, 1);
`ifdef BLK_WRAP_X_EN
    check("right_edge_x", int'(blkpos_x), 111);
`else
    check("right_edge_x", int'(blkpos_x), 1396);
`endif
    repeat (3) tick(0, 1, 1);
    for (int i = 0; i < 360; i++) tick(0, 1, 0);
`ifdef BLK_WRAP_X_EN
    check("left_edge_x", int'(blkpos_x), 60);
`else
    check("left_edge_x", int'(blkpos_x), 11);
`endif

    // Crush: platform scrolls to the crush threshold.
    set_all(50, 0, 0);
    tick(0, 0, 0);
    check("crush_pre_go", int'(game_over), 0);
    set_all(43, 0, 0);
    tick(0, 0, 0);
    check("crush_go", int'(game_over), 1);

    // Landing choice: smallest top wins, ties go to the lower index.
    set_all(0, 0, 0);
    tops[1] = 298; tops[2] = 300; tops[4] = 298;
    apply_plat();
    tick(1, 0, 0);
    for (int i = 0; i < 200 && mst == M_FALL; i++) tick(0, 0, 0);
    check("tie_y", int'(blkpos_y), 265);
    tops[4] = 200; apply_plat();
    tick(0, 0, 0);
    tops[1] = 290; apply_plat();
    tick(0, 0, 0);
    check("tie_track_y", int'(blkpos_y), 257);

    // Platform top below the block size clamps y at 0 and kills.
    tops[1] = 20; apply_plat();
    tick(0, 0, 0);
    check("underflow_y", int'(blkpos_y), 0);

    // Reset coincident with a tick while riding wins.
    tick(1, 0, 0);
    set_all(790, 0, 0);
    for (int i = 0; i < 200 && mst != M_RIDE; i++) tick(0, 0, 0);
    rst_n = 1'b0; frame_tick = 1'b1; btn_r = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; frame_tick = 1'b0; btn_r = 1'b0;
    check_reset_vals("sync_reset");
    model_reset();
    tick(0, 1, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
